// File: rtl/dsp_mult_share_arb_if.sv
// rtl/dsp_mult_share_arb_if.sv - request/response bundle for the shared multiply-add arbiter
interface dsp_mult_share_arb_if #(
  parameter int NREQ = 4,
  parameter int A_W  = 16,
  parameter int B_W  = 18,
  parameter int P_W  = 48,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
);
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*A_W-1:0] req_a;
  logic [NREQ*B_W-1:0] req_b;
  logic [NREQ-1:0]     req_c;
  logic                hold;
  logic [NREQ-1:0]     rsp_valid;
  logic [P_W-1:0]      rsp_p;
  logic [IDW-1:0]      rsp_id;
  logic                busy;

  // requester side: drives operands, sinks grants and results
  modport master (
    output req_valid, req_a, req_b, req_c, hold,
    input  req_ready, rsp_valid, rsp_p, rsp_id, busy
  );

  // arbiter side
  modport slave (
    input  req_valid, req_a, req_b, req_c, hold,
    output req_ready, rsp_valid, rsp_p, rsp_id, busy
  );
endinterface

// File: rtl/dsp_mult_share_arb.sv
// rtl/dsp_mult_share_arb.sv - round-robin sharing of one pipelined unsigned multiply-add
module dsp_mult_share_arb #(
  parameter int NREQ = 4,
  parameter int LAT  = 3,
  parameter int A_W  = 16,
  parameter int B_W  = 18,
  parameter int P_W  = 48
) (
  input  logic                 clk,
  input  logic                 rst,
  dsp_mult_share_arb_if.slave  bus
);
  localparam int IDW = $clog2(NREQ);

  logic [IDW-1:0]  ptr;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_id;
  logic            found;
  logic [IDW:0]    cand;
  logic            accept;
  logic [A_W-1:0]  sel_a;
  logic [B_W-1:0]  sel_b;
  logic            sel_c;

  // signals presented to the output register by the last pipeline stage
  logic            out_v;
  logic [IDW-1:0]  out_id;
  logic [P_W-1:0]  out_p;
  logic [NREQ-1:0] out_onehot;
  logic            pipe_any;

  // round-robin search starting at ptr; hold suppresses every grant
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    cand   = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NREQ)) begin
        cand = cand - (IDW+1)'(NREQ);
      end
      if (!found && !bus.hold && bus.req_valid[cand[IDW-1:0]]) begin
        found  = 1'b1;
        gnt_id = cand[IDW-1:0];
      end
    end
    if (found) begin
      gnt[gnt_id] = 1'b1;
    end
  end

  assign bus.req_ready = gnt;
  assign accept        = found;

  assign sel_a = bus.req_a[gnt_id*A_W +: A_W];
  assign sel_b = bus.req_b[gnt_id*B_W +: B_W];
  assign sel_c = bus.req_c[gnt_id];

  // priority moves just past the requester that was served
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= (gnt_id == IDW'(NREQ-1)) ? '0 : gnt_id + 1'b1;
    end
  end

  generate
    if (LAT == 1) begin : g_direct
      // the output register is the only stage
      assign out_v    = accept;
      assign out_id   = gnt_id;
      assign out_p    = P_W'(sel_a) * P_W'(sel_b) + P_W'(sel_c);
      assign pipe_any = 1'b0;
    end else begin : g_staged
      logic           s0_v;
      logic [IDW-1:0] s0_id;
      logic [A_W-1:0] s0_a;
      logic [B_W-1:0] s0_b;
      logic           s0_c;
      logic [P_W-1:0] s0_prod;

      // input register: the operand set of the granted requester plus its tag
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s0_v  <= 1'b0;
          s0_id <= '0;
          s0_a  <= '0;
          s0_b  <= '0;
          s0_c  <= 1'b0;
        end else begin
          s0_v  <= accept;
          s0_id <= gnt_id;
          s0_a  <= sel_a;
          s0_b  <= sel_b;
          s0_c  <= sel_c;
        end
      end

      assign s0_prod = P_W'(s0_a) * P_W'(s0_b) + P_W'(s0_c);

      if (LAT == 2) begin : g_short
        assign out_v    = s0_v;
        assign out_id   = s0_id;
        assign out_p    = s0_prod;
        assign pipe_any = s0_v;
      end else begin : g_long
        logic [LAT-3:0] pv;
        logic [IDW-1:0] pid [LAT-2];
        logic [P_W-1:0] pp  [LAT-2];

        // product stages carry the tagged result toward the output register
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            pv <= '0;
            for (int k = 0; k < LAT-2; k++) begin
              pid[k] <= '0;
              pp[k]  <= '0;
            end
          end else begin
            pv[0]  <= s0_v;
            pid[0] <= s0_id;
            pp[0]  <= s0_prod;
            for (int k = 1; k < LAT-2; k++) begin
              pv[k]  <= pv[k-1];
              pid[k] <= pid[k-1];
              pp[k]  <= pp[k-1];
            end
          end
        end

        assign out_v    = pv[LAT-3];
        assign out_id   = pid[LAT-3];
        assign out_p    = pp[LAT-3];
        assign pipe_any = s0_v | (|pv);
      end
    end
  endgenerate

  // route the strobe to the owning requester only
  always_comb begin
    out_onehot = '0;
    if (out_v) begin
      out_onehot[out_id] = 1'b1;
    end
  end

  // output register: single-cycle strobe, result and tag hold between strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.rsp_valid <= '0;
      bus.rsp_p     <= '0;
      bus.rsp_id    <= '0;
      bus.busy      <= 1'b0;
    end else begin
      bus.rsp_valid <= out_onehot;
      if (out_v) begin
        bus.rsp_p  <= out_p;
        bus.rsp_id <= out_id;
      end
      // something is in flight next cycle if a stage before the output is loaded
      bus.busy <= accept | pipe_any;
    end
  end
endmodule

// File: tb/tb_dsp_mult_share_arb.sv
// tb/tb_dsp_mult_share_arb.sv - scoreboard bench for the shared multiply-add arbiter
module tb_dsp_mult_share_arb;
  localparam int NREQ = 4;
  localparam int LAT  = 3;
  localparam int A_W  = 16;
  localparam int B_W  = 18;
  localparam int P_W  = 48;
  localparam int IDW  = 2;

  typedef struct {
    int             cyc;
    int             id;
    logic [P_W-1:0] p;
  } exp_t;

  typedef struct {
    logic [NREQ-1:0] v;
    logic [IDW-1:0]  id;
    logic [P_W-1:0]  p;
  } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  exp_t sb[$];
  rsp_t rsp_log[$];
  int   grant_log[$];
  int   acc_cnt[NREQ];
  int   seen[NREQ];
  int   rem[NREQ];
  int   mptr = 0;
  logic [P_W-1:0] last_p = '0;
  int   last_id = 0;

  dsp_mult_share_arb_if #(.NREQ(NREQ), .A_W(A_W), .B_W(B_W), .P_W(P_W)) bus ();

  dsp_mult_share_arb #(.NREQ(NREQ), .LAT(LAT), .A_W(A_W), .B_W(B_W), .P_W(P_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // edge counter used to time scoreboard entries
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int onehot2id(input logic [NREQ-1:0] v);
    int r = -1;
    for (int i = NREQ-1; i >= 0; i--) if (v[i]) r = i;
    return r;
  endfunction

  // cycle-level checker: scoreboard pops, response hold, busy and arbitration model
  initial begin
    exp_t e;
    rsp_t r;
    logic [NREQ-1:0] exp_rv;
    logic [NREQ-1:0] exp_gnt;
    logic [P_W-1:0]  ep;
    logic            exp_busy;
    int              gid;
    int              idx;
    bit              fnd;
    for (int i = 0; i < NREQ; i++) acc_cnt[i] = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        sb.delete();
        mptr = 0;
        last_p = '0;
        last_id = 0;
      end
      exp_busy = (sb.size() > 0);
      exp_rv = '0;
      if (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        exp_rv[e.id] = 1'b1;
        last_p = e.p;
        last_id = e.id;
      end
      check("rsp_valid", 64'(bus.rsp_valid), 64'(exp_rv));
      check("rsp_p", 64'(bus.rsp_p), 64'(last_p));
      check("rsp_id", 64'(bus.rsp_id), 64'(last_id));
      check("busy", 64'(bus.busy), 64'(exp_busy));
      if (bus.rsp_valid != '0) begin
        r.v = bus.rsp_valid;
        r.id = bus.rsp_id;
        r.p = bus.rsp_p;
        rsp_log.push_back(r);
      end
      exp_gnt = '0;
      fnd = 1'b0;
      gid = 0;
      if (!bus.hold) begin
        for (int k = 0; k < NREQ; k++) begin
          idx = (mptr + k) % NREQ;
          if (!fnd && bus.req_valid[idx]) begin
            fnd = 1'b1;
            gid = idx;
          end
        end
      end
      if (fnd) exp_gnt[gid] = 1'b1;
      check("req_ready", 64'(bus.req_ready), 64'(exp_gnt));
      if ((bus.req_ready & bus.req_valid) != '0) grant_log.push_back(onehot2id(bus.req_ready & bus.req_valid));
      if (fnd && !rst) begin
        ep = P_W'(bus.req_a[gid*A_W +: A_W]) * P_W'(bus.req_b[gid*B_W +: B_W]) + P_W'(bus.req_c[gid]);
        e.cyc = cyc + LAT;
        e.id = gid;
        e.p = ep;
        sb.push_back(e);
        mptr = (gid + 1) % NREQ;
        acc_cnt[gid]++;
      end
    end
  end

  task automatic set_req(input int i, input int a, input int b, input int c, input int n);
    bus.req_a[i*A_W +: A_W] = A_W'(a);
    bus.req_b[i*B_W +: B_W] = B_W'(b);
    bus.req_c[i] = c[0];
    bus.req_valid[i] = 1'b1;
    rem[i] = n;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (acc_cnt[i] != seen[i]) begin
        seen[i] = acc_cnt[i];
        if (rem[i] > 0) rem[i]--;
        if (rem[i] == 0) bus.req_valid[i] = 1'b0;
      end
    end
  endtask

  task automatic check_rsp(input string tag, input int k, input int id, input logic [P_W-1:0] p);
    if (k < rsp_log.size()) begin
      check({tag, "_v"}, 64'(rsp_log[k].v), 64'(1) << id);
      check({tag, "_id"}, 64'(rsp_log[k].id), 64'(id));
      check({tag, "_p"}, 64'(rsp_log[k].p), 64'(p));
    end else begin
      check({tag, "_count"}, 64'(rsp_log.size()), 64'(k + 1));
    end
  endtask

  task automatic check_grant(input string tag, input int k, input int id);
    if (k < grant_log.size()) check(tag, 64'(grant_log[k]), 64'(id));
    else check({tag, "_count"}, 64'(grant_log.size()), 64'(k + 1));
  endtask

  initial begin
    int l0;
    int r0;
    int bcnt;
    int n0;
    int n2;
    logic [P_W-1:0] wp;
    bus.req_valid = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.req_c = '0;
    bus.hold = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      seen[i] = 0;
      rem[i] = 0;
    end
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // all four at once from ptr=0
    l0 = grant_log.size();
    r0 = rsp_log.size();
    set_req(0, 33, 12, 0, 1);
    set_req(1, 1, 1, 0, 1);
    set_req(2, 2, 3, 1, 1);
    set_req(3, 0, 0, 0, 1);
    repeat (8) step();
    for (int k = 0; k < 4; k++) check_grant($sformatf("all4_grant%0d", k), l0 + k, k);
    check_rsp("all4_r0", r0 + 0, 0, 48'd396);
    check_rsp("all4_r1", r0 + 1, 1, 48'd1);
    check_rsp("all4_r2", r0 + 2, 2, 48'd7);
    check_rsp("all4_r3", r0 + 3, 3, 48'd0);

    // fairness between req0 and req2
    l0 = grant_log.size();
    set_req(0, 3, 4, 0, 4);
    set_req(2, 5, 6, 1, 4);
    repeat (8) step();
    for (int k = 0; k < 8; k++) check_grant($sformatf("fair_grant%0d", k), l0 + k, (k % 2 == 0) ? 0 : 2);
    n0 = 0;
    n2 = 0;
    for (int k = l0; k < grant_log.size(); k++) begin
      if (grant_log[k] == 0) n0++;
      if (grant_log[k] == 2) n2++;
    end
    check("fair_count0", 64'(n0), 64'd4);
    check("fair_count2", 64'(n2), 64'd4);
    repeat (4) step();

    // single requester with busy window
    r0 = rsp_log.size();
    set_req(0, 38, 22, 1, 1);
    step();
    bcnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.busy === 1'b1) bcnt++;
    end
    check("single_busy_cycles", 64'(bcnt), 64'd3);
    check_rsp("single", r0, 0, 48'd837);
    step();

    // hold blocks a pending request
    r0 = rsp_log.size();
    bus.hold = 1'b1;
    set_req(1, 5, 7, 0, 1);
    repeat (3) begin
      @(negedge clk);
      check("hold_ready_zero", 64'(bus.req_ready), 64'd0);
    end
    @(posedge clk);
    #1 bus.hold = 1'b0;
    repeat (5) step();
    check_rsp("hold", r0, 1, 48'd35);

    // width corner
    r0 = rsp_log.size();
    set_req(3, 65535, 262143, 1, 1);
    repeat (5) step();
    check_rsp("wide", r0, 3, 48'd17179541506);
    wp = (r0 < rsp_log.size()) ? rsp_log[r0].p : '1;
    check("wide_upper_zero", 64'(wp[47:34]), 64'd0);

    // reset with two operations in flight
    set_req(1, 9, 9, 0, 1);
    set_req(2, 8, 8, 0, 1);
    step();
    step();
    r0 = rsp_log.size();
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_rsp_p", 64'(bus.rsp_p), 64'd0);
    check("rst_rsp_id", 64'(bus.rsp_id), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    repeat (5) step();
    check("rst_no_strobe", 64'(rsp_log.size()), 64'(r0));
    l0 = grant_log.size();
    set_req(0, 2, 2, 0, 1);
    set_req(3, 4, 4, 0, 1);
    step();
    check_grant("rst_ptr_winner", l0, 0);
    repeat (6) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
